// File: rtl/fairy_fetch_stage.sv
// rtl/fairy_fetch_stage.sv - instruction fetch: PC, single-outstanding SRAM-like request, one-entry decode buffer
// Exception/ERET flush and redirect; decode branches honour the MIPS delay slot.
module fairy_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exception_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        adel_o
);

  typedef enum logic {S_REQ, S_DATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        discard_q, discard_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_adel_q, buf_adel_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic req;
  logic buf_free;
  logic aligned;
  logic addr_hs;
  logic data_hs;
  logic slot_unrequested;

  always_comb begin
    state_d       = state_q;
    npc_d         = npc_q;
    out_pc_d      = out_pc_q;
    discard_d     = discard_q;
    buf_valid_d   = buf_valid_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    buf_adel_d    = buf_adel_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    buf_free = !buf_valid_q || out_ready_i;
    aligned  = (npc_q[1:0] == 2'b00);
    req      = reset_n && (state_q == S_REQ) && aligned && buf_free;
    addr_hs  = req && inst_addr_ok_i;
    data_hs  = (state_q == S_DATA) && inst_data_ok_i;
    // The branch being popped has its delay slot still sitting in npc.
    slot_unrequested = (npc_q == buf_pc_q + 32'd4);

    if (buf_valid_q && out_ready_i) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (addr_hs) begin
          state_d  = S_DATA;
          out_pc_d = npc_q;
          if (pend_valid_q) begin
            npc_d        = pend_target_q;
            pend_valid_d = 1'b0;
          end else begin
            npc_d = npc_q + 32'd4;
          end
        end else if (reset_n && !aligned && buf_free) begin
          buf_valid_d = 1'b1;
          buf_inst_d  = 32'h0;
          buf_pc_d    = npc_q;
          buf_adel_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (data_hs) begin
          state_d = S_REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            buf_valid_d = 1'b1;
            buf_inst_d  = inst_rdata_i;
            buf_pc_d    = out_pc_q;
            buf_adel_d  = 1'b0;
          end
        end
      end
      default: state_d = S_REQ;
    endcase

    if (branch_valid_i) begin
      if (slot_unrequested && !addr_hs) begin
        pend_valid_d  = 1'b1;
        pend_target_d = branch_target_i;
      end else begin
        npc_d = branch_target_i;
      end
    end

    // Flush overrides everything above; a transaction still on the bus must be drained silently.
    if (exception_i || eret_i) begin
      npc_d        = exception_i ? EXC_VECTOR : epc_i;
      buf_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
      if (addr_hs || ((state_q == S_DATA) && !data_hs)) begin
        state_d   = S_DATA;
        discard_d = 1'b1;
      end else begin
        state_d   = S_REQ;
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_REQ;
      npc_q         <= RESET_PC;
      out_pc_q      <= 32'h0;
      discard_q     <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_inst_q    <= 32'h0;
      buf_pc_q      <= 32'h0;
      buf_adel_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      npc_q         <= npc_d;
      out_pc_q      <= out_pc_d;
      discard_q     <= discard_d;
      buf_valid_q   <= buf_valid_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
      buf_adel_q    <= buf_adel_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign inst_req_o  = req;
  assign inst_addr_o = npc_q;
  assign out_valid_o = buf_valid_q;
  assign inst_o      = buf_inst_q;
  assign pc_o        = buf_pc_q;
  assign adel_o      = buf_adel_q;

endmodule

// File: tb/tb_fairy_fetch_stage.sv
// tb/tb_fairy_fetch_stage.sv - directed bench for fairy_fetch_stage
// Request addresses and decode outputs are scoreboarded against queues filled by the stimulus.
module tb_fairy_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exception_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        branch_valid_i;
  logic [31:0] branch_target_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        adel_o;

  always #5 clk = ~clk;

  fairy_fetch_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .exception_i     (exception_i),
    .eret_i          (eret_i),
    .epc_i           (epc_i),
    .branch_valid_i  (branch_valid_i),
    .branch_target_i (branch_target_i),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_addr_ok_i  (inst_addr_ok_i),
    .inst_data_ok_i  (inst_data_ok_i),
    .inst_rdata_i    (inst_rdata_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .adel_o          (adel_o)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] exp_req[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic        hold_en;
  logic [31:0] hold_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24010001;
    return a ^ 32'h3C1F0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic a);
    entry_t e;
    e.inst = i;
    e.pc   = p;
    e.adel = a;
    exp_q.push_back(e);
  endtask

  // One clock: score handshakes at the negedge, then play the memory after the posedge.
  task automatic tick();
    logic        hs;
    logic [31:0] ha;
    entry_t      e;
    @(negedge clk);
    hs = inst_req_o && inst_addr_ok_i;
    ha = inst_addr_o;
    if (hs) begin
      n_checks++;
      assert (exp_req.size() != 0) else begin
        n_fails++;
        $error("FAIL req_unexpected: observed request %h expected none", ha);
      end
      if (exp_req.size() != 0) check("req_addr", ha, exp_req.pop_front());
    end
    if (out_valid_o && out_ready_i) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fails++;
        $error("FAIL out_unexpected: observed pc %h expected no output", pc_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_inst", inst_o, e.inst);
        check("out_pc", pc_o, e.pc);
        check("out_adel", {31'h0, adel_o}, {31'h0, e.adel});
      end
    end
    @(posedge clk);
    #1;
    inst_data_ok_i = hs && !(hold_en && (ha == hold_addr));
    inst_rdata_i   = mem_word(ha);
  endtask

  initial begin
    reset_n = 1'b0; exception_i = 1'b0; eret_i = 1'b0; epc_i = 32'h0;
    branch_valid_i = 1'b0; branch_target_i = 32'h0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
    out_ready_i = 1'b1; hold_en = 1'b0; hold_addr = 32'h0;
    tick(); tick();
    check("rst_req", inst_req_o, 0);
    check("rst_addr", inst_addr_o, 32'hBFC00000);
    check("rst_valid", out_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_adel", adel_o, 0);

    // first fetch and minimum latency
    inst_addr_ok_i = 1'b1;
    exp_req.push_back(32'hBFC00000);
    exp_req.push_back(32'hBFC00004);
    push_exp(32'h24010001, 32'hBFC00000, 1'b0);
    reset_n = 1'b1;
    #1;
    check("first_req", inst_req_o, 1);
    check("first_addr", inst_addr_o, 32'hBFC00000);
    tick();
    check("lat_t1_valid", out_valid_o, 0);
    tick();
    check("lat_t2_valid", out_valid_o, 1);
    check("lat_t2_pc", pc_o, 32'hBFC00000);
    check("lat_t2_inst", inst_o, 32'h24010001);
    check("next_addr", inst_addr_o, 32'hBFC00004);

    // decode back-pressure
    out_ready_i = 1'b0;
    #1;
    check("stall_req", inst_req_o, 0);
    tick(); tick();
    check("stall_req2", inst_req_o, 0);
    check("stall_hold", out_valid_o, 1);
    out_ready_i = 1'b1;
    push_exp(mem_word(32'hBFC00004), 32'hBFC00004, 1'b0);
    #1;
    check("pop_req", inst_req_o, 1);
    check("pop_addr", inst_addr_o, 32'hBFC00004);
    tick();
    inst_addr_ok_i = 1'b0;
    tick();

    // exception while waiting for BFC00010's data
    hold_en = 1'b1; hold_addr = 32'hBFC00010; inst_addr_ok_i = 1'b1;
    exp_req.push_back(32'hBFC00008);
    exp_req.push_back(32'hBFC0000C);
    exp_req.push_back(32'hBFC00010);
    push_exp(mem_word(32'hBFC00008), 32'hBFC00008, 1'b0);
    push_exp(mem_word(32'hBFC0000C), 32'hBFC0000C, 1'b0);
    repeat (5) tick();
    check("exc_in_data", inst_req_o, 0);
    exception_i = 1'b1;
    tick();
    exception_i = 1'b0;
    check("exc_npc", inst_addr_o, 32'hBFC00380);
    check("exc_wait", inst_req_o, 0);
    inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEADBEEF; inst_addr_ok_i = 1'b0;
    tick();
    hold_en = 1'b0;
    check("exc_discard", out_valid_o, 0);
    check("exc_req", inst_req_o, 1);
    check("exc_req_addr", inst_addr_o, 32'hBFC00380);

    // buffered entry flushed by ERET to an unaligned EPC
    inst_addr_ok_i = 1'b1;
    exp_req.push_back(32'hBFC00380);
    tick();
    inst_addr_ok_i = 1'b0; out_ready_i = 1'b0;
    tick();
    check("eret_pre_valid", out_valid_o, 1);
    check("eret_pre_pc", pc_o, 32'hBFC00380);
    eret_i = 1'b1; epc_i = 32'h80001002;
    tick();
    eret_i = 1'b0;
    check("eret_flush", out_valid_o, 0);
    check("eret_no_req", inst_req_o, 0);
    check("eret_npc", inst_addr_o, 32'h80001002);
    tick();
    check("adel_valid", out_valid_o, 1);
    check("adel_flag", adel_o, 1);
    check("adel_pc", pc_o, 32'h80001002);
    check("adel_inst", inst_o, 0);
    check("adel_no_req", inst_req_o, 0);

    // exception beats a same-cycle branch and leaves nothing pending
    push_exp(32'h0, 32'h80001002, 1'b1);
    out_ready_i = 1'b1; exception_i = 1'b1;
    branch_valid_i = 1'b1; branch_target_i = 32'h80000100;
    tick();
    exception_i = 1'b0; branch_valid_i = 1'b0;
    check("excbr_npc", inst_addr_o, 32'hBFC00380);
    check("excbr_valid", out_valid_o, 0);
    inst_addr_ok_i = 1'b1;
    exp_req.push_back(32'hBFC00380);
    tick();
    inst_addr_ok_i = 1'b0;
    check("excbr_no_pend", inst_addr_o, 32'hBFC00384);
    push_exp(mem_word(32'hBFC00380), 32'hBFC00380, 1'b0);
    tick();

    // branch with delay slot not yet requested
    eret_i = 1'b1; epc_i = 32'h80000000;
    tick();
    eret_i = 1'b0;
    check("brA_npc", inst_addr_o, 32'h80000000);
    inst_addr_ok_i = 1'b1;
    exp_req.push_back(32'h80000000);
    tick();
    inst_addr_ok_i = 1'b0;
    push_exp(mem_word(32'h80000000), 32'h80000000, 1'b0);
    tick();
    check("brA_pc", pc_o, 32'h80000000);
    check("brA_slot_addr", inst_addr_o, 32'h80000004);
    branch_valid_i = 1'b1; branch_target_i = 32'h80000100;
    tick();
    branch_valid_i = 1'b0;
    check("brA_slot_first", inst_addr_o, 32'h80000004);
    exp_req.push_back(32'h80000004);
    exp_req.push_back(32'h80000100);
    push_exp(mem_word(32'h80000004), 32'h80000004, 1'b0);
    push_exp(mem_word(32'h80000100), 32'h80000100, 1'b0);
    inst_addr_ok_i = 1'b1;
    tick();
    check("brA_target_next", inst_addr_o, 32'h80000100);
    tick(); tick();
    inst_addr_ok_i = 1'b0;
    tick();
    check("brA_after", inst_addr_o, 32'h80000104);

    // same branch, delay slot accepted in the branch cycle
    eret_i = 1'b1; epc_i = 32'h80000000;
    tick();
    eret_i = 1'b0;
    inst_addr_ok_i = 1'b1;
    exp_req.push_back(32'h80000000);
    push_exp(mem_word(32'h80000000), 32'h80000000, 1'b0);
    tick(); tick();
    check("brB_pc", pc_o, 32'h80000000);
    check("brB_req", inst_req_o, 1);
    branch_valid_i = 1'b1; branch_target_i = 32'h80000100;
    exp_req.push_back(32'h80000004);
    exp_req.push_back(32'h80000100);
    push_exp(mem_word(32'h80000004), 32'h80000004, 1'b0);
    push_exp(mem_word(32'h80000100), 32'h80000100, 1'b0);
    tick();
    branch_valid_i = 1'b0;
    check("brB_target_next", inst_addr_o, 32'h80000100);
    tick(); tick();
    inst_addr_ok_i = 1'b0;
    tick(); tick();
    check("end_addr", inst_addr_o, 32'h80000104);
    check("end_out_q", exp_q.size(), 0);
    check("end_req_q", exp_req.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
